// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types for the genrom read-port arbiter:
//     arb_state_t : transfer sequencer states (IDLE / ISSUE / CAPTURE)
//     req_id_t    : requester identifier, REQ_F (instruction fetch) or
//                   REQ_D (operand/data path)
//     other_req() : the requester that is not the one given, used to
//                   move the round-robin pointer after a grant.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_F = 1'b0;
  localparam req_id_t REQ_D = 1'b1;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_F) ? REQ_D : REQ_F;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2
//   Combinational two-input round-robin pick.
//   Ports:
//     f_req, d_req : in  request levels of the two requesters
//     ptr          : in  requester preferred when both request
//     winner       : out selected requester (REQ_F when nobody requests)
//     any          : out at least one request is present
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic    f_req,
  input  logic    d_req,
  input  req_id_t ptr,
  output req_id_t winner,
  output logic    any
);

  // Pick: a lone request wins outright, a tie goes to the pointer.
  always_comb begin
    any    = f_req | d_req;
    winner = REQ_F;
    if (f_req && d_req) begin
      winner = ptr;
    end else if (d_req) begin
      winner = REQ_D;
    end else begin
      winner = REQ_F;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter and sequencer for the single genrom read port,
//   shared by instruction fetch (f_*) and the operand/data path (d_*).
//   The winner's address, size and bounds are latched and held at the ROM
//   for its one-cycle registered read; the returned data/error are then
//   registered into the winner's response and flagged with a valid pulse.
//   Ports:
//     clk, reset             : clock, asynchronous active-low reset
//     x_req/x_addr/x_extra   : request level, byte address, size code
//     x_lower/x_upper        : access bounds of this requester
//     x_grant                : one-cycle pulse, request accepted
//     x_valid/x_data/x_error : one-cycle response pulse with data/error
//     mem_addr/mem_extra     : latched address/size towards genrom
//     rom_lower/upper_bound  : latched bounds towards genrom
//     mem_data/mem_error     : genrom response, one cycle after the address
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_DEPTH = 4,
  parameter int MEM_EXTRA = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  // instruction fetch requester
  input  logic                          f_req,
  input  logic [MEM_DEPTH:0]            f_addr,
  input  logic [MEM_EXTRA-1:0]          f_extra,
  input  logic [MEM_DEPTH:0]            f_lower,
  input  logic [MEM_DEPTH:0]            f_upper,
  output logic                          f_grant,
  output logic                          f_valid,
  output logic [(2**MEM_EXTRA)*8-1:0]   f_data,
  output logic                          f_error,
  // operand/data requester
  input  logic                          d_req,
  input  logic [MEM_DEPTH:0]            d_addr,
  input  logic [MEM_EXTRA-1:0]          d_extra,
  input  logic [MEM_DEPTH:0]            d_lower,
  input  logic [MEM_DEPTH:0]            d_upper,
  output logic                          d_grant,
  output logic                          d_valid,
  output logic [(2**MEM_EXTRA)*8-1:0]   d_data,
  output logic                          d_error,
  // genrom side
  output logic [MEM_DEPTH:0]            mem_addr,
  output logic [MEM_EXTRA-1:0]          mem_extra,
  output logic [MEM_DEPTH:0]            rom_lower_bound,
  output logic [MEM_DEPTH:0]            rom_upper_bound,
  input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
  input  logic                          mem_error
);

  localparam int AW = MEM_DEPTH + 1;
  localparam int DW = (2 ** MEM_EXTRA) * 8;

  arb_state_t         state_q, state_d;
  req_id_t            ptr_q, ptr_d;
  req_id_t            owner_q, owner_d;
  req_id_t            win;
  logic               any_req;
  logic               accept;

  logic [AW-1:0]        addr_q, addr_d;
  logic [MEM_EXTRA-1:0] extra_q, extra_d;
  logic [AW-1:0]        lower_q, lower_d;
  logic [AW-1:0]        upper_q, upper_d;

  logic               f_grant_q, f_grant_d;
  logic               d_grant_q, d_grant_d;
  logic               f_valid_q, f_valid_d;
  logic               d_valid_q, d_valid_d;
  logic [DW-1:0]      f_data_q, f_data_d;
  logic [DW-1:0]      d_data_q, d_data_d;
  logic               f_error_q, f_error_d;
  logic               d_error_q, d_error_d;

  arb_rr2 u_rr (
    .f_req  (f_req),
    .d_req  (d_req),
    .ptr    (ptr_q),
    .winner (win),
    .any    (any_req)
  );

  // A new transfer may start from IDLE or overlap the CAPTURE edge of the
  // previous one, which gives the two-cycle back-to-back cadence.
  assign accept = any_req && ((state_q == IDLE) || (state_q == CAPTURE));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests seen during ISSUE wait for the CAPTURE edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (any_req) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output/datapath next values: latch the winner on accept, return the
  // ROM response to the owner at the end of CAPTURE.
  always_comb begin
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    extra_d   = extra_q;
    lower_d   = lower_q;
    upper_d   = upper_q;
    f_grant_d = 1'b0;
    d_grant_d = 1'b0;
    f_valid_d = 1'b0;
    d_valid_d = 1'b0;
    f_data_d  = f_data_q;
    d_data_d  = d_data_q;
    f_error_d = f_error_q;
    d_error_d = d_error_q;

    if (accept) begin
      ptr_d   = other_req(win);
      owner_d = win;
      if (win == REQ_D) begin
        addr_d    = d_addr;
        extra_d   = d_extra;
        lower_d   = d_lower;
        upper_d   = d_upper;
        d_grant_d = 1'b1;
      end else begin
        addr_d    = f_addr;
        extra_d   = f_extra;
        lower_d   = f_lower;
        upper_d   = f_upper;
        f_grant_d = 1'b1;
      end
    end else begin
      ptr_d   = ptr_q;
      owner_d = owner_q;
    end

    // owner_q still names the finishing transfer even if a new winner is
    // being latched on this same edge.
    if (state_q == CAPTURE) begin
      if (owner_q == REQ_D) begin
        d_valid_d = 1'b1;
        d_data_d  = mem_data;
        d_error_d = mem_error;
      end else begin
        f_valid_d = 1'b1;
        f_data_d  = mem_data;
        f_error_d = mem_error;
      end
    end else begin
      f_valid_d = 1'b0;
      d_valid_d = 1'b0;
    end
  end

  // Datapath and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q     <= REQ_F;
      owner_q   <= REQ_F;
      addr_q    <= {AW{1'b0}};
      extra_q   <= {MEM_EXTRA{1'b0}};
      lower_q   <= {AW{1'b0}};
      upper_q   <= {AW{1'b1}};
      f_grant_q <= 1'b0;
      d_grant_q <= 1'b0;
      f_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      f_data_q  <= {DW{1'b0}};
      d_data_q  <= {DW{1'b0}};
      f_error_q <= 1'b0;
      d_error_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      extra_q   <= extra_d;
      lower_q   <= lower_d;
      upper_q   <= upper_d;
      f_grant_q <= f_grant_d;
      d_grant_q <= d_grant_d;
      f_valid_q <= f_valid_d;
      d_valid_q <= d_valid_d;
      f_data_q  <= f_data_d;
      d_data_q  <= d_data_d;
      f_error_q <= f_error_d;
      d_error_q <= d_error_d;
    end
  end

  assign f_grant         = f_grant_q;
  assign d_grant         = d_grant_q;
  assign f_valid         = f_valid_q;
  assign d_valid         = d_valid_q;
  assign f_data          = f_data_q;
  assign d_data          = d_data_q;
  assign f_error         = f_error_q;
  assign d_error         = d_error_q;
  assign mem_addr        = addr_q;
  assign mem_extra       = extra_q;
  assign rom_lower_bound = lower_q;
  assign rom_upper_bound = upper_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives directed and random request traffic into mem_arbiter, models the
//   genrom (byte[i] = i, 32 bytes) and predicts every output each cycle with
//   a transaction-level model: a grant may start at an edge no earlier than
//   two edges after the previous grant, ties go to the pointer which then
//   points away from the winner, and a grant at edge e returns its response
//   at edge e+2.
module tb_mem_arbiter;

  localparam int MEM_DEPTH = 4;
  localparam int MEM_EXTRA = 4;
  localparam int AW = MEM_DEPTH + 1;
  localparam int DW = (2 ** MEM_EXTRA) * 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 f_req = 1'b0, d_req = 1'b0;
  logic [AW-1:0]        f_addr = '0, d_addr = '0;
  logic [MEM_EXTRA-1:0] f_extra = '0, d_extra = '0;
  logic [AW-1:0]        f_lower = '0, d_lower = '0;
  logic [AW-1:0]        f_upper = 5'd31, d_upper = 5'd31;
  logic                 f_grant, d_grant, f_valid, d_valid, f_error, d_error;
  logic [DW-1:0]        f_data, d_data;
  logic [AW-1:0]        mem_addr, rom_lower_bound, rom_upper_bound;
  logic [MEM_EXTRA-1:0] mem_extra;
  logic [DW-1:0]        mem_data = '0;
  logic                 mem_error = 1'b0;

  mem_arbiter #(.MEM_DEPTH(MEM_DEPTH), .MEM_EXTRA(MEM_EXTRA)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_extra(f_extra), .f_lower(f_lower), .f_upper(f_upper),
    .f_grant(f_grant), .f_valid(f_valid), .f_data(f_data), .f_error(f_error),
    .d_req(d_req), .d_addr(d_addr), .d_extra(d_extra), .d_lower(d_lower), .d_upper(d_upper),
    .d_grant(d_grant), .d_valid(d_valid), .d_data(d_data), .d_error(d_error),
    .mem_addr(mem_addr), .mem_extra(mem_extra),
    .rom_lower_bound(rom_lower_bound), .rom_upper_bound(rom_upper_bound),
    .mem_data(mem_data), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a, input logic [MEM_EXTRA-1:0] x);
    logic [DW-1:0] w;
    w = '0;
    for (int j = 0; j < 16; j++)
      if (j < (1 << int'(x))) w[j*8 +: 8] = 8'((int'(a) + j) % 32);
    return w;
  endfunction

  function automatic logic rom_err(input logic [AW-1:0] a, input logic [MEM_EXTRA-1:0] x,
                                   input logic [AW-1:0] lo, input logic [AW-1:0] up);
    int last;
    last = int'(a) + (1 << int'(x)) - 1;
    return (int'(a) < int'(lo)) || (last > int'(up)) || (last > 31);
  endfunction

  // genrom stand-in: registered read of whatever the arbiter presents.
  always @(posedge clk) begin
    mem_data  <= rom_word(mem_addr, mem_extra);
    mem_error <= rom_err(mem_addr, mem_extra, rom_lower_bound, rom_upper_bound);
  end

  typedef struct {
    int            at_edge;
    int            who;
    logic [DW-1:0] data;
    logic          err;
  } xfer_t;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  int ptr = 0;
  int next_ok = 0;
  int f_wait = 0, d_wait = 0;
  xfer_t pend[$];

  logic [1:0]           e_grant, e_valid;
  logic [DW-1:0]        e_data [2];
  logic                 e_err [2];
  logic [AW-1:0]        e_addr, e_lo, e_up;
  logic [MEM_EXTRA-1:0] e_extra;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  // Predict the effect of the next rising edge, take it, then compare.
  task automatic step();
    xfer_t t;
    int    w;
    e_grant = 2'b00;
    e_valid = 2'b00;
    if (!reset) begin
      ptr = 0; next_ok = 0; pend.delete();
      e_data[0] = '0; e_data[1] = '0; e_err[0] = 1'b0; e_err[1] = 1'b0;
      e_addr = '0; e_extra = '0; e_lo = '0; e_up = 5'h1F;
    end else begin
      if (pend.size() > 0 && pend[0].at_edge == k + 1) begin
        t = pend.pop_front();
        e_valid[t.who] = 1'b1;
        e_data[t.who]  = t.data;
        e_err[t.who]   = t.err;
      end
      if ((k + 1 >= next_ok) && (f_req || d_req)) begin
        w = (f_req && d_req) ? ptr : (d_req ? 1 : 0);
        ptr = 1 - w;
        next_ok = k + 3;
        e_grant[w] = 1'b1;
        e_addr  = (w == 1) ? d_addr  : f_addr;
        e_extra = (w == 1) ? d_extra : f_extra;
        e_lo    = (w == 1) ? d_lower : f_lower;
        e_up    = (w == 1) ? d_upper : f_upper;
        t.at_edge = k + 3;
        t.who  = w;
        t.data = rom_word(e_addr, e_extra);
        t.err  = rom_err(e_addr, e_extra, e_lo, e_up);
        pend.push_back(t);
      end
    end
    @(posedge clk);
    k++;
    @(negedge clk);
    check("f_grant", DW'(f_grant), DW'(e_grant[0]));
    check("d_grant", DW'(d_grant), DW'(e_grant[1]));
    check("f_valid", DW'(f_valid), DW'(e_valid[0]));
    check("d_valid", DW'(d_valid), DW'(e_valid[1]));
    check("f_data", f_data, e_data[0]);
    check("d_data", d_data, e_data[1]);
    check("f_error", DW'(f_error), DW'(e_err[0]));
    check("d_error", DW'(d_error), DW'(e_err[1]));
    check("mem_addr", DW'(mem_addr), DW'(e_addr));
    check("mem_extra", DW'(mem_extra), DW'(e_extra));
    check("rom_lower", DW'(rom_lower_bound), DW'(e_lo));
    check("rom_upper", DW'(rom_upper_bound), DW'(e_up));
    check("valid_excl", DW'(f_valid & d_valid), DW'(1'b0));
  endtask

  task automatic new_f();
    logic [AW-1:0] a, b;
    f_addr = AW'($urandom_range(31)); f_extra = MEM_EXTRA'($urandom_range(2));
    a = AW'($urandom_range(31)); b = AW'($urandom_range(31));
    if ($urandom_range(3) == 0) begin
      f_lower = (a < b) ? a : b; f_upper = (a < b) ? b : a;
    end else begin
      f_lower = '0; f_upper = 5'd31;
    end
  endtask

  task automatic new_d();
    logic [AW-1:0] a, b;
    d_addr = AW'($urandom_range(31)); d_extra = MEM_EXTRA'($urandom_range(2));
    a = AW'($urandom_range(31)); b = AW'($urandom_range(31));
    if ($urandom_range(3) == 0) begin
      d_lower = (a < b) ? a : b; d_upper = (a < b) ? b : a;
    end else begin
      d_lower = '0; d_upper = 5'd31;
    end
  endtask

  // Run n cycles; on a grant a requester re-requests with keep_pct chance,
  // an idle requester raises a new request with raise_pct chance.
  task automatic run(input int n, input int keep_pct, input int raise_pct);
    for (int i = 0; i < n; i++) begin
      step();
      f_wait = (f_req && !f_grant) ? f_wait + 1 : 0;
      d_wait = (d_req && !d_grant) ? d_wait + 1 : 0;
      if (f_req) check("f_starve", DW'(f_wait <= 8), DW'(1'b1));
      if (d_req) check("d_starve", DW'(d_wait <= 8), DW'(1'b1));
      if (f_req && f_grant) begin
        if (int'($urandom_range(99)) < keep_pct) new_f(); else f_req = 1'b0;
      end else if (!f_req && int'($urandom_range(99)) < raise_pct) begin
        new_f(); f_req = 1'b1;
      end
      if (d_req && d_grant) begin
        if (int'($urandom_range(99)) < keep_pct) new_d(); else d_req = 1'b0;
      end else if (!d_req && int'($urandom_range(99)) < raise_pct) begin
        new_d(); d_req = 1'b1;
      end
    end
  endtask

  initial begin
    // reset held three cycles, then five idle cycles
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    run(5, 0, 0);

    // simultaneous F(4)/D(9): F first, then D
    f_req = 1'b1; f_addr = 5'd4; f_extra = 4'd0;
    d_req = 1'b1; d_addr = 5'd9; d_extra = 4'd0;
    run(8, 0, 0);
    // the next tie goes to F again
    f_req = 1'b1; f_addr = 5'd6;
    d_req = 1'b1; d_addr = 5'd7;
    run(8, 0, 0);

    // F only, single byte at address 2
    f_req = 1'b1; f_addr = 5'd2; f_extra = 4'd0;
    run(6, 0, 0);

    // D out of its own bounds (8..15) at address 3
    d_req = 1'b1; d_addr = 5'd3; d_extra = 4'd0; d_lower = 5'd8; d_upper = 5'd15;
    run(6, 0, 0);
    d_lower = 5'd0; d_upper = 5'd31;

    // reset pulsed during the ISSUE cycle of an F transfer
    f_req = 1'b1; f_addr = 5'd5; f_extra = 4'd0;
    step();
    f_req = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    run(6, 0, 0);

    // both held high over many transfers
    f_req = 1'b1; f_addr = 5'd10; d_req = 1'b1; d_addr = 5'd20;
    run(17, 100, 0);
    f_req = 1'b0; d_req = 1'b0;
    run(4, 0, 0);

    // random traffic
    run(600, 25, 30);
    f_req = 1'b0; d_req = 1'b0;
    run(6, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter and sequencer for the single `genrom` read port shared by the core's instruction-fetch path (requester F) and its operand/data path (requester D). It latches the winning request's address, extra width and bounds, and holds them stable through the ROM's one-cycle registered read. It then returns the captured data and error to the winner with a one-cycle `valid` pulse. The block sits between `core` and `genrom`, replacing the core's direct `mem_addr`/`mem_extra` connection.

## Interface

Parameters:
- `MEM_DEPTH`, default 4: ROM address width. All addresses and bounds are `MEM_DEPTH+1` bits.
- `MEM_EXTRA`, default 4: extra-width field. Data width is `2**MEM_EXTRA*8` bits.

Ports. The `f_*` and `d_*` groups are identical, shown once as `x_*`.
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset: 0 clears all state immediately.
- `x_req`  in  1  request. Level signal, held until `x_grant` is seen.
- `x_addr`  in  MEM_DEPTH+1  byte address.
- `x_extra`  in  MEM_EXTRA  access size code.
- `x_lower`, `x_upper`  in  MEM_DEPTH+1  bounds for this requester.
- `x_grant`  out  1  one-cycle pulse: request accepted, inputs may change.
- `x_valid`  out  1  one-cycle pulse: `x_data`/`x_error` are valid.
- `x_data`  out  2**MEM_EXTRA*8  read data.
- `x_error`  out  1  bound/addr error of this access.
- `mem_addr`, `rom_lower_bound`, `rom_upper_bound`  out  MEM_DEPTH+1  to `genrom`.
- `mem_extra`  out  MEM_EXTRA  to `genrom`.
- `mem_data`  in  2**MEM_EXTRA*8  from `genrom`, valid one cycle after the address edge.
- `mem_error`  in  1  from `genrom`, same timing as `mem_data`.

## Operation

- FSM states:
  - IDLE: no transfer; waits for a request.
  - ISSUE: address held at the ROM for one cycle.
  - CAPTURE: `mem_data`/`mem_error` are sampled at the end of this state.
- IDLE transitions:
  - Any `req` → latch the winner's addr, extra and bounds into the `mem_*`/`rom_*` registers, set the owner, go to ISSUE.
  - No request → stay in IDLE.
- ISSUE → CAPTURE unconditionally.
- CAPTURE:
  - Register `mem_data`/`mem_error` into the owner's `x_data`/`x_error` and set the owner's `x_valid`.
  - If any `req` is pending, arbitrate and latch the next winner on the same edge, go to ISSUE. Otherwise go to IDLE.
- Arbitration:
  - A single request wins outright.
  - With simultaneous requests, the requester named by the priority pointer wins.
  - On every grant the pointer moves to the other requester.
  - The pointer resets to F.
- `x_grant` is registered: high for exactly the ISSUE cycle of that requester's transfer.
- The requester must hold `req` and all inputs stable from assertion through its `x_grant` cycle.
- A requester keeping `req` high after its grant is a new request.
- Non-owner `x_data`/`x_error` hold their last value. `x_valid` is never high for both requesters at once.
- `mem_*`/`rom_*` outputs hold their last latched value in IDLE.
- Errors are not filtered: `mem_error` is passed to the owner unchanged, and `x_error` is meaningful only with `x_valid`.

## Timing

- Reset values:
  - State IDLE, pointer F.
  - `x_grant`, `x_valid`, `x_error` = 0; `x_data` = 0.
  - `mem_addr` = 0, `mem_extra` = 0, `rom_lower_bound` = 0, `rom_upper_bound` = all ones.
- Latency, with `req` sampled in IDLE at edge E:
  - `grant` high in cycle E+1.
  - ROM samples the address at edge E+1.
  - Data captured at edge E+2.
  - `valid` high in cycle E+3.
- Throughput: back-to-back transfers every 2 cycles. The valid of transfer n coincides with the grant of transfer n+1.
- Reset asserted mid-transfer: the transfer is abandoned and no `valid` is produced. After release the block resumes from IDLE.
- A request arriving during ISSUE is not serviced until the CAPTURE edge.

## Structure

- Package `mem_arb_pkg`:
  - state enum `arb_state_t` {IDLE, ISSUE, CAPTURE}.
  - requester id typedef `req_id_t` with constants `REQ_F = 0`, `REQ_D = 1`.
- Sub-module `arb_rr2`: combinational two-input round-robin pick from the `req` pair and the pointer; outputs a winner id and a `any` flag.
- The top level holds the FSM, pointer, latched ROM-side registers and per-requester response registers.

## Test plan

ROM image: byte[i] = i for i in 0..31. `MEM_EXTRA=4`, extra 0 = 1-byte read.

- Reset held low 3 cycles, then released:
  - all outputs at reset values;
  - `rom_upper_bound` = 5'h1F;
  - no grant or valid for 5 idle cycles.
- F only: `f_req`, `f_addr=2`, `f_extra=0`:
  - `f_grant` 1 cycle later;
  - `f_valid` 3 cycles after the request edge;
  - `f_data[7:0]=8'h02`, `f_error=0`.
- F and D simultaneous (F addr 4, D addr 9), both held high:
  - F granted first, D on the following CAPTURE edge;
  - `f_data[7:0]=4` with `f_valid`, then 2 cycles later `d_data[7:0]=9`;
  - the next tie goes to F again.
- D with `d_lower=8`, `d_upper=15`, `d_addr=3`:
  - `rom_*_bound` show 8/15 during ISSUE;
  - `d_valid` with `d_error=1`;
  - `f_valid` stays 0.
- `reset` pulsed low during ISSUE of an F transfer: no `f_valid` ever appears for that transfer, and the state returns to IDLE.
- F and D both held high for 8 transfers: grants alternate F, D, F, D…; each `valid` carries the correct requester's data; `f_valid` and `d_valid` are never high together.
